// File: rtl/fifo_delay_pkg.sv
// rtl/fifo_delay_pkg.sv - shared types and helpers for the multi-channel delay line
//
// Purpose : FSM state type, BRAM address-width helper and ring-offset helper.
// Contents: state_t, addr_w(), wrap_sub()
package fifo_delay_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        CAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Address width of the shared RAM holding every channel's ring back to back.
    function automatic int addr_w(input int channels, input int maxlen);
        int depth;
        depth = channels * maxlen;
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // (a - b) mod m for a < m and b <= m: subtract, then add m back once on borrow.
    function automatic int unsigned wrap_sub(input int unsigned a,
                                             input int unsigned b,
                                             input int unsigned m);
        int unsigned d;
        d = a - b;
        if (a < b) begin
            d = d + m;
        end
        return d;
    endfunction

endpackage

// File: rtl/delay_bram_sdp.sv
// rtl/delay_bram_sdp.sv - simple dual-port RAM, registered read, read-before-write
//
// Purpose : inferred RAM with one write port and one 1-cycle-latency read port.
//           A same-address read and write in one cycle returns the old word.
// Ports   : clk, wr_en/wr_addr/wr_data (write port),
//           rd_en/rd_addr -> rd_data (registered read port)
module delay_bram_sdp #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 1024,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // No reset on the array or read register so the tools can map this to block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/fifo_delay_multi.sv
// rtl/fifo_delay_multi.sv - CHANNELS audio delay lines time-multiplexed on one RAM
//
// Purpose : each sample_tick snapshots in/len and sweeps every channel through
//           a read (RD) and a capture/write (CAP) cycle, then advances the shared
//           write pointer and fill count (DONE).
// Ports   : clk, rst (async, active high), enable, sample_tick,
//           in  [CHANNELS*WIDTH] flat samples, len [CHANNELS*LENW] flat lengths,
//           out [CHANNELS*WIDTH] registered delayed samples,
//           busy (sweep in progress), done (sweep-complete pulse),
//           overrun (sticky: tick arrived while busy)
module fifo_delay_multi
    import fifo_delay_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int MAXLEN   = 1024,
    parameter int CHANNELS = 4,
    parameter int LENW     = $clog2(MAXLEN + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic                      sample_tick,
    input  logic [CHANNELS*WIDTH-1:0] in,
    input  logic [CHANNELS*LENW-1:0]  len,
    output logic [CHANNELS*WIDTH-1:0] out,
    output logic                      busy,
    output logic                      done,
    output logic                      overrun
);

    localparam int PW = (MAXLEN > 1) ? $clog2(MAXLEN) : 1;
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int AW = addr_w(CHANNELS, MAXLEN);

    state_t state;
    state_t state_nxt;

    logic [CW-1:0]             ch;
    logic [CHANNELS*WIDTH-1:0] in_snap;
    logic [CHANNELS*LENW-1:0]  len_snap;
    logic [PW-1:0]             wr_ptr;
    logic [LENW-1:0]           fill_cnt;

    logic             start;
    logic             last_ch;
    logic             rd_en;
    logic             wr_en;
    logic [AW-1:0]    rd_addr;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] rd_data;
    logic [WIDTH-1:0] cur_in;
    logic [LENW-1:0]  cur_len;
    logic [LENW-1:0]  leff;
    logic [PW-1:0]    rd_off;
    logic [WIDTH-1:0] sel;

    assign start   = enable && sample_tick && (state == IDLE);
    assign last_ch = (ch == CW'(CHANNELS - 1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RD;
            RD:      state_nxt = CAP;
            CAP:     state_nxt = last_ch ? DONE : RD;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        rd_en = 1'b0;
        wr_en = 1'b0;
        busy  = 1'b0;
        case (state)
            RD:      begin rd_en = 1'b1; busy = 1'b1; end
            CAP:     begin wr_en = 1'b1; busy = 1'b1; end
            DONE:    busy = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    // Per-channel datapath, driven from the snapshot only
    always_comb begin
        cur_in  = in_snap[ch*WIDTH +: WIDTH];
        cur_len = len_snap[ch*LENW +: LENW];
        leff    = (cur_len > LENW'(MAXLEN)) ? LENW'(MAXLEN) : cur_len;
        rd_off  = PW'(wrap_sub(32'(wr_ptr), 32'(leff), MAXLEN));
        rd_addr = AW'(32'(ch) * MAXLEN + 32'(rd_off));
        wr_addr = AW'(32'(ch) * MAXLEN + 32'(wr_ptr));
        // Zero length bypasses the ring; lengths not yet covered by history read as silence.
        if (leff == '0) begin
            sel = cur_in;
        end else if (leff > fill_cnt) begin
            sel = '0;
        end else begin
            sel = rd_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out      <= '0;
            done     <= 1'b0;
            overrun  <= 1'b0;
            wr_ptr   <= '0;
            fill_cnt <= '0;
            ch       <= '0;
            in_snap  <= '0;
            len_snap <= '0;
        end else begin
            done <= (state == DONE);
            if (enable && sample_tick && (state != IDLE)) begin
                overrun <= 1'b1;
            end
            if (start) begin
                in_snap  <= in;
                len_snap <= len;
                ch       <= '0;
            end
            if (state == CAP) begin
                out[ch*WIDTH +: WIDTH] <= sel;
                if (!last_ch) begin
                    ch <= ch + 1'b1;
                end
            end
            if (state == DONE) begin
                wr_ptr <= (wr_ptr == PW'(MAXLEN - 1)) ? '0 : wr_ptr + 1'b1;
                if (fill_cnt < LENW'(MAXLEN)) begin
                    fill_cnt <= fill_cnt + 1'b1;
                end
            end
        end
    end

    delay_bram_sdp #(
        .WIDTH (WIDTH),
        .DEPTH (CHANNELS * MAXLEN),
        .AW    (AW)
    ) u_bram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (cur_in),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_fifo_delay_multi.sv
// tb/tb_fifo_delay_multi.sv - directed self-checking bench for fifo_delay_multi
module tb_fifo_delay_multi;

    localparam int WIDTH    = 12;
    localparam int MAXLEN   = 8;
    localparam int CHANNELS = 2;
    localparam int LENW     = 4;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic                      enable = 1'b1;
    logic                      sample_tick = 1'b0;
    logic [CHANNELS*WIDTH-1:0] din = '0;
    logic [CHANNELS*LENW-1:0]  dlen = '0;
    logic [CHANNELS*WIDTH-1:0] dout;
    logic                      busy;
    logic                      done;
    logic                      overrun;

    int n_cmp = 0;
    int n_err = 0;
    int done_total = 0;
    int hist0[$];
    int hist1[$];
    int last_e0 = 0;
    int last_e1 = 0;
    int sweep_id = 0;

    fifo_delay_multi #(
        .WIDTH    (WIDTH),
        .MAXLEN   (MAXLEN),
        .CHANNELS (CHANNELS),
        .LENW     (LENW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .sample_tick (sample_tick),
        .in          (din),
        .len         (dlen),
        .out         (dout),
        .busy        (busy),
        .done        (done),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done) done_total++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int expect_out(input int h[$], input int l);
        int leff;
        int n;
        leff = (l > MAXLEN) ? MAXLEN : l;
        n = h.size() - 1;
        return (n >= leff) ? h[n - leff] : 0;
    endfunction

    // One tick, 20 clocks long. glitch: overwrite in0 one clock after the tick.
    // dbl: second tick 3 clocks after the first.
    task automatic run_sweep(input int a0, input int a1, input int l0, input int l1,
                             input bit glitch, input bit dbl);
        int d0;
        d0 = done_total;
        @(negedge clk);
        din  = {WIDTH'(a1), WIDTH'(a0)};
        dlen = {LENW'(l1), LENW'(l0)};
        sample_tick = 1'b1;
        for (int i = 1; i < 20; i++) begin
            @(negedge clk);
            if (i == 1) begin
                sample_tick = 1'b0;
                if (glitch) din[WIDTH-1:0] = 12'hFFF;
                check($sformatf("busy s%0d", sweep_id), 32'(busy), 32'(enable));
            end
            if (dbl && i == 3) sample_tick = 1'b1;
            if (dbl && i == 4) sample_tick = 1'b0;
        end
        if (enable) begin
            hist0.push_back(a0);
            hist1.push_back(a1);
            last_e0 = expect_out(hist0, l0);
            last_e1 = expect_out(hist1, l1);
        end
        check($sformatf("out0 s%0d", sweep_id), 32'(dout[WIDTH-1:0]), 32'(last_e0));
        check($sformatf("out1 s%0d", sweep_id), 32'(dout[2*WIDTH-1:WIDTH]), 32'(last_e1));
        check($sformatf("done s%0d", sweep_id), 32'(done_total - d0), enable ? 32'd1 : 32'd0);
        sweep_id++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        hist0.delete();
        hist1.delete();
        last_e0 = 0;
        last_e1 = 0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst out", 32'(dout), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst overrun", 32'(overrun), 32'd0);
        rst = 1'b0;

        // Basic delay, then a live shortening of ch0
        for (int k = 1; k <= 10; k++) run_sweep(k, 100 + k, 3, 5, 1'b0, 1'b0);
        for (int k = 11; k <= 13; k++) run_sweep(k, 100 + k, 1, 5, 1'b0, 1'b0);

        // Ticks with enable low: outputs hold, no done, no overrun
        enable = 1'b0;
        for (int k = 0; k < 2; k++) run_sweep(77, 88, 1, 5, 1'b0, 1'b0);
        check("dis overrun", 32'(overrun), 32'd0);
        enable = 1'b1;

        // Boundaries: bypass and full-depth across the pointer wrap, then clamp
        do_reset();
        for (int k = 1; k <= 12; k++) run_sweep(200 + k, 300 + k, 0, 8, 1'b0, 1'b0);
        for (int k = 13; k <= 16; k++) run_sweep(200 + k, 300 + k, 0, 12, 1'b0, 1'b0);

        // Snapshot: upstream change right after the tick must not leak in
        run_sweep(12'h5A5, 400, 0, 12, 1'b1, 1'b0);
        run_sweep(12'h123, 401, 1, 12, 1'b0, 1'b0);

        // Overrun: second tick while busy; only one sweep runs
        check("pre overrun", 32'(overrun), 32'd0);
        run_sweep(12'h321, 402, 1, 12, 1'b0, 1'b1);
        check("overrun set", 32'(overrun), 32'd1);
        run_sweep(12'h322, 403, 1, 12, 1'b0, 1'b0);
        check("overrun sticky", 32'(overrun), 32'd1);

        // Reset in CAP of ch1: outputs clear asynchronously
        @(negedge clk);
        din  = {12'd500, 12'd501};
        dlen = {4'd5, 4'd3};
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        repeat (3) @(negedge clk);
        check("pre rst out0", 32'(dout[WIDTH-1:0] != '0), 32'd1);
        rst = 1'b1;
        #1;
        check("mid rst out", 32'(dout), 32'd0);
        check("mid rst busy", 32'(busy), 32'd0);
        check("mid rst overrun", 32'(overrun), 32'd0);
        check("mid rst done", 32'(done), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        hist0.delete();
        hist1.delete();
        last_e0 = 0;
        last_e1 = 0;

        // Stale RAM contents must stay masked until the history covers len
        for (int k = 1; k <= 7; k++) run_sweep(600 + k, 700 + k, 3, 5, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_delay_multi.md
Name: fifo_delay_multi

Overview:
- Multi-channel successor to the single-channel BRAM delay line: CHANNELS independent audio delay lines, each with its own run-time length, time-multiplexed onto one simple-dual-port BRAM.
- Runs entirely in the system clock domain. A one-cycle sample_tick from the sample-rate generator replaces a separate sample clock.
- Sits between the synth voice mixer and the reverb/echo stages. It adds warm-up masking, zero-length bypass, length clamping and overrun reporting.

Parameters:
- WIDTH, 16, sample width in bits (two's complement; the block passes samples through and never interprets them).
- MAXLEN, 1024, maximum delay per channel in samples; this is also the ring depth per channel.
- CHANNELS, 4, number of independent delay lines.
- LENW, $clog2(MAXLEN+1), width of each len field.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- enable  in  1  when low, sample_tick is ignored and all state holds.
- sample_tick  in  1  one-clk pulse per audio sample; starts one sweep.
- in  in  CHANNELS*WIDTH  flat input samples; channel c occupies bits [c*WIDTH +: WIDTH].
- len  in  CHANNELS*LENW  flat delay lengths in samples, one per channel.
- out  out  CHANNELS*WIDTH  flat delayed samples, registered.
- busy  out  1  high while a sweep is in progress.
- done  out  1  one-clk pulse when a sweep completes.
- overrun  out  1  sticky flag: a tick arrived while busy.

Behaviour:
- Reset (async assert, sync release):
  - out = 0, busy = 0, done = 0, overrun = 0.
  - wr_ptr = 0, fill_cnt = 0, FSM = IDLE.
  - BRAM contents are not cleared; fill_cnt masks stale data.
- Snapshot: when IDLE, enable = 1 and sample_tick = 1, the in and len buses are latched into internal registers. The sweep uses only the snapshot, so upstream may change in/len immediately afterwards.
- FSM states: IDLE -> RD -> CAP -> (RD for next channel | DONE) -> IDLE.
  - RD: present read address c*MAXLEN + rd_off(c) to the BRAM.
  - CAP: BRAM data is valid. Write the snapshot sample to address c*MAXLEN + wr_ptr. Update out[c].
  - DONE: increment wr_ptr modulo MAXLEN (wrap MAXLEN-1 -> 0). Saturating-increment fill_cnt up to MAXLEN. Pulse done.
- Timing, with the tick sampled at edge E0:
  - out[c] updates at edge E(2c+2).
  - done is high for the single cycle after edge E(2*CHANNELS+1).
  - busy is high from E0 through E(2*CHANNELS+1), then low.
  - Total sweep is 2*CHANNELS+2 cycles. Integration requirement: tick period ≥ 2*CHANNELS+2 clks.
- Effective length: Leff = min(len[c], MAXLEN).
- Read offset: rd_off = (wr_ptr - Leff) mod MAXLEN. Compute with LENW+1 bits and a conditional add of MAXLEN; no % operator.
  - Leff = MAXLEN reads the word at wr_ptr before it is overwritten in the same CAP cycle (read-before-write order required).
- Output selection in CAP:
  - Leff = 0: out[c] = snapshot in[c] (bypass). The BRAM is still written.
  - Leff > fill_cnt: out[c] = 0 (warm-up masking).
  - Otherwise: out[c] = BRAM read data.
  - Net result: out[c] after sweep n equals in[c] from sweep n-Leff, or 0 if that sweep predates reset.
- Tick while busy: ignored, and overrun is set to 1. It stays set until reset.
- Tick while enable = 0: ignored; overrun is not set.
- enable falling mid-sweep: the sweep completes normally. enable gates only the start of a sweep.
- Reset mid-sweep: abort immediately and return to the reset values above. A partial BRAM write is harmless because fill_cnt is 0.
- Channels share wr_ptr and fill_cnt; each channel has its own length.

Decomposition:
- Package fifo_delay_pkg:
  - state_t enum {IDLE, RD, CAP, DONE}.
  - function addr_w(CHANNELS, MAXLEN) returning $clog2(CHANNELS*MAXLEN).
  - function wrap_sub used for rd_off.
- Sub-module delay_bram_sdp #(WIDTH, DEPTH):
  - Simple dual port, one write port and one registered read port, 1-cycle read latency, read-before-write on address collision.
  - Inferred RAM, no reset on the memory array.

Test Plan (bench: CHANNELS=2, MAXLEN=8, WIDTH=12, tick every 20 clks):
- Basic delay: len = {3, 5}; feed ch0 = 1,2,3,… and ch1 = 101,102,… -> ch0 outputs 0,0,0,1,2,…; ch1 outputs 0×5 then 101,102,…; done pulses once per tick.
- Boundaries: len0 = 0 and len1 = 8 -> ch0 tracks in0 in the same sweep; ch1 yields 0 for 8 sweeps, then in1 delayed by 8 across the wr_ptr 7 -> 0 wrap.
- Clamp and live change: len1 = 12 -> behaves exactly as 8. Change len0 from 3 to 1 mid-stream -> the next sweep outputs the sample from 1 sweep earlier, with no X values.
- Overrun: raise a second tick 3 clks after the first -> overrun = 1 and sticky, and only one sweep runs (1 done). Set enable = 0 with ticks -> outputs hold and overrun is not set.
- Snapshot: change in0 to 0xFFF one clk after a tick -> the stored value is the pre-change sample.
- Reset mid-sweep: assert rst in CAP of ch1 -> all outputs are 0 asynchronously. After release, every channel outputs 0 until fill_cnt ≥ len (stale BRAM data is never output).
